// File: rtl/regbank_access_arbiter.sv
// regbank_access_arbiter
// Shares the register bank write port (Sel_C/Data_C) and the B read port
// (Sel_B/Data_B) between the core sequencer (c_*) and the debug/loader port
// (d_*). Each access is sequenced over the bank's registered timing. Illegal
// register codes are blocked. A starvation counter guarantees that debug
// eventually wins over a continuously requesting core.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   c_req/c_we/c_addr/c_wdata   core request, op (1 = write), code, write data
//   c_gnt                core request accepted (combinational, IDLE only)
//   c_done               core op complete (1-cycle pulse)
//   d_req/d_we/d_addr/d_wdata   debug request, same meaning as core
//   d_gnt, d_done        debug grant / complete
//   rdata                read result, valid while c_done or d_done is high
//   err                  illegal-code flag, valid while c_done or d_done is high
//   rb_sel_b, rb_sel_c   bank Sel_B / Sel_C (IDLE_SEL when no access)
//   rb_data_c            bank Data_C
//   rb_data_b            bank Data_B
//   busy                 sequencer not in IDLE
module regbank_access_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SEL_W      = 6,
  parameter int unsigned W_CODE     = 34,
  parameter int unsigned IDLE_SEL   = 63,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [SEL_W-1:0]  c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [SEL_W-1:0]  d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [SEL_W-1:0]  rb_sel_b,
  output logic [SEL_W-1:0]  rb_sel_c,
  output logic [DATA_W-1:0] rb_data_c,
  input  logic [DATA_W-1:0] rb_data_b,
  output logic              busy
);

  localparam int unsigned CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int unsigned NUM_GP = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_CAPT  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   starve_cnt, starve_cnt_nxt;

  // Command latched on the granting edge
  logic               op_dbg, op_dbg_nxt;
  logic               op_we, op_we_nxt;
  logic               op_legal, op_legal_nxt;
  logic [SEL_W-1:0]   op_addr, op_addr_nxt;

  // Next values of the registered outputs
  logic [SEL_W-1:0]   sel_b_nxt, sel_c_nxt;
  logic [DATA_W-1:0]  data_c_nxt, rdata_nxt;
  logic               c_done_nxt, d_done_nxt, err_nxt, busy_nxt;

  // Granted command, muxed from the winning requester
  logic               gnt_any;
  logic               gnt_we;
  logic [SEL_W-1:0]   gnt_addr;
  logic [DATA_W-1:0]  gnt_wdata;
  logic               gnt_legal;

  // Arbitration: grants only in IDLE; debug wins a tie once core has starved it
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!reset && state == ST_IDLE) begin
      if (d_req && (!c_req || starve_cnt == CNT_W'(STARVE_MAX))) begin
        d_gnt = 1'b1;
      end else if (c_req) begin
        c_gnt = 1'b1;
      end
    end
  end

  // Command of the granted requester and its legality
  always_comb begin
    gnt_any   = c_gnt | d_gnt;
    gnt_we    = d_gnt ? d_we    : c_we;
    gnt_addr  = d_gnt ? d_addr  : c_addr;
    gnt_wdata = d_gnt ? d_wdata : c_wdata;
    gnt_legal = (gnt_addr < SEL_W'(NUM_GP)) || (gnt_addr == SEL_W'(W_CODE));
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt      = state;
    starve_cnt_nxt = starve_cnt;
    op_dbg_nxt     = op_dbg;
    op_we_nxt      = op_we;
    op_legal_nxt   = op_legal;
    op_addr_nxt    = op_addr;
    sel_b_nxt      = SEL_W'(IDLE_SEL);
    sel_c_nxt      = SEL_W'(IDLE_SEL);
    data_c_nxt     = rb_data_c;
    rdata_nxt      = rdata;
    c_done_nxt     = 1'b0;
    d_done_nxt     = 1'b0;
    err_nxt        = 1'b0;

    // Starvation counter counts core grants that overtook a waiting debug
    if (!d_req || d_gnt) begin
      starve_cnt_nxt = '0;
    end else if (c_gnt && starve_cnt < CNT_W'(STARVE_MAX)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end

    case (state)
      ST_IDLE: begin
        if (gnt_any) begin
          state_nxt    = ST_ISSUE;
          op_dbg_nxt   = d_gnt;
          op_we_nxt    = gnt_we;
          op_legal_nxt = gnt_legal;
          op_addr_nxt  = gnt_addr;
          // Selects are registered so they present the code during ISSUE
          if (gnt_legal) begin
            if (gnt_we) begin
              sel_c_nxt  = gnt_addr;
              data_c_nxt = gnt_wdata;
            end else begin
              sel_b_nxt  = gnt_addr;
            end
          end
        end
      end

      ST_ISSUE: begin
        if (!op_legal) begin
          state_nxt  = ST_IDLE;
          err_nxt    = 1'b1;
          rdata_nxt  = '0;
          c_done_nxt = !op_dbg;
          d_done_nxt = op_dbg;
        end else if (op_we) begin
          state_nxt  = ST_IDLE;
          c_done_nxt = !op_dbg;
          d_done_nxt = op_dbg;
        end else begin
          // Bank updates Data_B on this edge; capture it in CAPT
          state_nxt  = ST_CAPT;
        end
      end

      ST_CAPT: begin
        state_nxt  = ST_IDLE;
        rdata_nxt  = rb_data_b;
        c_done_nxt = !op_dbg;
        d_done_nxt = op_dbg;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      op_dbg     <= 1'b0;
      op_we      <= 1'b0;
      op_legal   <= 1'b0;
      op_addr    <= SEL_W'(IDLE_SEL);
      rb_sel_b   <= SEL_W'(IDLE_SEL);
      rb_sel_c   <= SEL_W'(IDLE_SEL);
      rb_data_c  <= '0;
      rdata      <= '0;
      c_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_cnt_nxt;
      op_dbg     <= op_dbg_nxt;
      op_we      <= op_we_nxt;
      op_legal   <= op_legal_nxt;
      op_addr    <= op_addr_nxt;
      rb_sel_b   <= sel_b_nxt;
      rb_sel_c   <= sel_c_nxt;
      rb_data_c  <= data_c_nxt;
      rdata      <= rdata_nxt;
      c_done     <= c_done_nxt;
      d_done     <= d_done_nxt;
      err        <= err_nxt;
      busy       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_regbank_access_arbiter.sv
// Testbench for regbank_access_arbiter: a register bank stand-in driven by the
// DUT, a transaction-level reference model checked every cycle, directed
// scenarios with literal expectations, and a randomized two-requester phase.
module tb_regbank_access_arbiter;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned SEL_W      = 6;
  localparam int unsigned W_CODE     = 34;
  localparam int unsigned IDLE_SEL   = 63;
  localparam int unsigned STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              c_req, c_we, d_req, d_we;
  logic [SEL_W-1:0]  c_addr, d_addr;
  logic [DATA_W-1:0] c_wdata, d_wdata;
  logic              c_gnt, c_done, d_gnt, d_done, err, busy;
  logic [DATA_W-1:0] rdata, rb_data_c, rb_data_b;
  logic [SEL_W-1:0]  rb_sel_b, rb_sel_c;

  regbank_access_arbiter #(
    .DATA_W(DATA_W), .SEL_W(SEL_W), .W_CODE(W_CODE),
    .IDLE_SEL(IDLE_SEL), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_done(c_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_done(d_done),
    .rdata(rdata), .err(err),
    .rb_sel_b(rb_sel_b), .rb_sel_c(rb_sel_c), .rb_data_c(rb_data_c),
    .rb_data_b(rb_data_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks;
  int n_errors;
  int c_activity;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit mapped(input logic [SEL_W-1:0] a);
    return (a < 6'd32) || (a == 6'(W_CODE));
  endfunction

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 16'((i * 32'h1357) ^ 32'hA5A5);
  endfunction

  function automatic logic [SEL_W-1:0] rand_addr();
    int r;
    logic [SEL_W-1:0] a;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      a = 6'(32 + $urandom_range(0, 31));
      if (a == 6'(W_CODE)) a = 6'd35;
    end else if (r == 1) begin
      a = 6'(W_CODE);
    end else begin
      a = 6'($urandom_range(0, 31));
    end
    return a;
  endfunction

  // Register bank stand-in: registered write on Sel_C, registered Data_B on Sel_B
  logic [DATA_W-1:0] bank [64];
  initial begin
    for (int i = 0; i < 64; i++) bank[i] = init_val(i);
    rb_data_b = '0;
    forever begin
      @(posedge clk);
      if (mapped(rb_sel_c)) bank[rb_sel_c] <= rb_data_c;
      if (mapped(rb_sel_b)) rb_data_b <= bank[rb_sel_b];
    end
  end

  // Reference model: one outstanding transaction, timing from its grant cycle
  logic [DATA_W-1:0] mem [64];
  initial begin
    bit               have_op, op_who, op_we, op_legal, idle, e_cg, e_dg, e_cd, e_dd;
    int               op_g, op_lat, starve;
    logic [SEL_W-1:0] op_addr, e_sb, e_sc;
    logic [DATA_W-1:0] op_wdata, op_rd;
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    have_op = 0; starve = 0; op_g = 0; op_lat = 0;
    forever begin
      @(negedge clk);
      if (c_gnt || c_done) c_activity++;
      if (reset) begin
        chk("rst_busy", busy, 0);
        chk("rst_gnt", {c_gnt, d_gnt}, 0);
        chk("rst_done", {c_done, d_done}, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_sel_b", rb_sel_b, IDLE_SEL);
        chk("rst_sel_c", rb_sel_c, IDLE_SEL);
        have_op = 0;
        starve  = 0;
      end else begin
        idle = !have_op || (cyc >= op_g + op_lat);
        e_sb = 6'(IDLE_SEL);
        e_sc = 6'(IDLE_SEL);
        if (have_op && cyc == op_g + 1 && op_legal) begin
          if (op_we) e_sc = op_addr;
          else       e_sb = op_addr;
        end
        e_cd = have_op && (cyc == op_g + op_lat) && !op_who;
        e_dd = have_op && (cyc == op_g + op_lat) && op_who;
        chk("busy", busy, have_op && cyc > op_g && cyc < op_g + op_lat);
        chk("sel_b", rb_sel_b, e_sb);
        chk("sel_c", rb_sel_c, e_sc);
        if (e_sc != 6'(IDLE_SEL)) chk("data_c", rb_data_c, op_wdata);
        chk("c_done", c_done, e_cd);
        chk("d_done", d_done, e_dd);
        chk("err", err, (e_cd || e_dd) && !op_legal);
        if ((e_cd || e_dd) && (!op_we || !op_legal)) chk("rdata", rdata, op_rd);

        e_cg = 0; e_dg = 0;
        if (idle) begin
          if (d_req && (!c_req || starve == STARVE_MAX)) e_dg = 1;
          else if (c_req) e_cg = 1;
        end
        chk("c_gnt", c_gnt, e_cg);
        chk("d_gnt", d_gnt, e_dg);

        if (!d_req || e_dg) starve = 0;
        else if (e_cg) starve++;

        if (e_cg || e_dg) begin
          have_op  = 1;
          op_g     = cyc;
          op_who   = e_dg;
          op_we    = e_dg ? d_we    : c_we;
          op_addr  = e_dg ? d_addr  : c_addr;
          op_wdata = e_dg ? d_wdata : c_wdata;
          op_legal = mapped(op_addr);
          if (!op_legal) begin
            op_lat = 2;
            op_rd  = '0;
          end else if (op_we) begin
            op_lat = 2;
            mem[op_addr] = op_wdata;
          end else begin
            op_lat = 3;
            op_rd  = mem[op_addr];
          end
        end
      end
    end
  end

  // Issue one op and observe grant-to-done latency and results
  task automatic do_op(input bit who, input bit we, input logic [SEL_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, output int lat,
                       output logic [DATA_W-1:0] rd, output logic e,
                       output int sc_cnt, output int sb_cnt);
    int g;
    bit got;
    lat = -1; rd = '0; e = 1'b0; sc_cnt = 0; sb_cnt = 0; g = 0;
    @(posedge clk); #1;
    if (!who) begin c_req = 1; c_we = we; c_addr = addr; c_wdata = wd; end
    else      begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (who ? d_gnt : c_gnt) begin got = 1; g = cyc; end
    end
    if (!got) chk("gnt_timeout", 0, 1);
    @(posedge clk); #1;
    c_req = 0; d_req = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rb_sel_c != 6'(IDLE_SEL)) sc_cnt++;
      if (rb_sel_b != 6'(IDLE_SEL)) sb_cnt++;
      if (who ? d_done : c_done) begin got = 1; lat = cyc - g; rd = rdata; e = err; end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, sc, sb, n, dn;
    logic [DATA_W-1:0] rd;
    logic e, cg, dg;
    logic [9:0] ordv;
    bit got;
    reset = 1;
    c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Core write then read of r5
    do_op(0, 1, 6'd5, 16'h1234, lat, rd, e, sc, sb);
    chk("t1_wr_lat", lat, 2);
    chk("t1_selc_cycles", sc, 1);
    do_op(0, 0, 6'd5, 16'h0000, lat, rd, e, sc, sb);
    chk("t1_rd_lat", lat, 3);
    chk("t1_rd_data", rd, 16'h1234);
    chk("t1_rd_err", e, 0);

    // Debug write/read of the W register, core stays silent
    c_activity = 0;
    do_op(1, 1, 6'd34, 16'h00AB, lat, rd, e, sc, sb);
    chk("t2_wr_lat", lat, 2);
    do_op(1, 0, 6'd34, 16'h0000, lat, rd, e, sc, sb);
    chk("t2_rd_lat", lat, 3);
    chk("t2_rd_data", rd, 16'h00AB);
    chk("t2_core_quiet", c_activity, 0);

    // Both request writes continuously: grant order C,C,C,C,D,C,C,C,C,D
    @(posedge clk); #1;
    c_req = 1; c_we = 1; c_addr = 6'd1; c_wdata = 16'h1111;
    d_req = 1; d_we = 1; d_addr = 6'd2; d_wdata = 16'h2222;
    n = 0; ordv = '0;
    for (int i = 0; i < 100 && n < 10; i++) begin
      @(negedge clk);
      if (c_gnt) begin ordv[n] = 1'b0; n++; end
      if (d_gnt && n < 10) begin ordv[n] = 1'b1; n++; end
    end
    @(posedge clk); #1;
    c_req = 0; d_req = 0;
    chk("t3_grant_count", n, 10);
    chk("t3_grant_order", ordv, 10'b1000010000);

    // Illegal code read
    do_op(0, 0, 6'd40, 16'h0000, lat, rd, e, sc, sb);
    chk("t4_lat", lat, 2);
    chk("t4_err", e, 1);
    chk("t4_rdata", rd, 0);
    chk("t4_no_sel", sc + sb, 0);

    // Reset during CAPT of a read
    @(posedge clk); #1;
    c_req = 1; c_we = 0; c_addr = 6'd7;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (c_gnt) got = 1;
    end
    if (!got) chk("t5_gnt_timeout", 0, 1);
    @(posedge clk); #1;
    c_req = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
    chk("t5_busy_now", busy, 0);
    chk("t5_selb_now", rb_sel_b, IDLE_SEL);
    chk("t5_selc_now", rb_sel_c, IDLE_SEL);
    dn = 0;
    repeat (2) begin @(negedge clk); if (c_done) dn++; end
    @(posedge clk); #1;
    reset = 0;
    repeat (3) begin @(negedge clk); if (c_done) dn++; end
    chk("t5_no_done", dn, 0);
    do_op(0, 1, 6'd7, 16'hBEEF, lat, rd, e, sc, sb);
    chk("t5_wr_lat", lat, 2);
    do_op(0, 0, 6'd7, 16'h0000, lat, rd, e, sc, sb);
    chk("t5_rd_lat", lat, 3);
    chk("t5_rd_data", rd, 16'hBEEF);

    // Idle: selects parked, bank untouched
    repeat (10) begin
      @(negedge clk);
      chk("t6_idle_sel", {rb_sel_b, rb_sel_c}, {6'(IDLE_SEL), 6'(IDLE_SEL)});
    end
    for (int i = 0; i < 32; i++) chk("t6_bank", bank[i], mem[i]);

    // Randomized traffic from both requesters
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      cg = c_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (cg) c_req = 0;
      if (dg) d_req = 0;
      if (!c_req && $urandom_range(0, 2) == 0) begin
        c_req = 1; c_we = 1'($urandom_range(0, 1));
        c_addr = rand_addr(); c_wdata = 16'($urandom);
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req = 1; d_we = 1'($urandom_range(0, 1));
        d_addr = rand_addr(); d_wdata = 16'($urandom);
      end
    end
    // Let outstanding requests drain
    for (int i = 0; i < 40 && (c_req || d_req); i++) begin
      @(negedge clk);
      cg = c_gnt; dg = d_gnt;
      @(posedge clk); #1;
      if (cg) c_req = 0;
      if (dg) d_req = 0;
    end
    chk("t7_drained", {c_req, d_req}, 0);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 32; i++) chk("t7_bank", bank[i], mem[i]);
    chk("t7_bank_w", bank[W_CODE], mem[W_CODE]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
